// File: rtl/qs_src.sv
// Stimulus source for a sorter: emits an LFSR-generated packet, then checks the sorted reply
// for framing, ordering, checksum and timeout, reporting one status pulse per command.
module qs_src #(
   parameter int unsigned W     = 32,
   parameter int unsigned LEN_W = 8,
   parameter int unsigned TMO   = 65535
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_vld,
   input  logic [LEN_W-1:0] cmd_len,
   input  logic [31:0]      cmd_seed,
   output logic             cmd_rdy_r,
   output logic             tx_vld_r,
   output logic             tx_sop_r,
   output logic             tx_eop_r,
   output logic [W-1:0]     tx_dat_r,
   input  logic             tx_rdy,
   input  logic             rx_vld,
   input  logic             rx_sop,
   input  logic             rx_eop,
   input  logic             rx_err,
   input  logic [W-1:0]     rx_dat,
   output logic             stat_vld_r,
   output logic             stat_pass_r,
   output logic [3:0]       stat_code_r
);

   localparam int unsigned SW   = W + LEN_W;
   localparam int unsigned TW   = (TMO < 2) ? 1 : $clog2(TMO + 1);
   localparam logic [31:0] POLY = 32'h8020_0003;

   // Bit positions inside the failure code {timeout, sum, order, frame}
   localparam int unsigned CTmo = 3;
   localparam int unsigned CSum = 2;
   localparam int unsigned COrd = 1;
   localparam int unsigned CFrm = 0;

   typedef enum logic [1:0] {StIdle, StTx, StWaitRx, StDone} state_e;

   state_e           state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] tx_cnt_q, tx_cnt_d;
   logic [LEN_W-1:0] rx_cnt_q, rx_cnt_d;
   logic [31:0]      lfsr_q, lfsr_d;
   logic [SW-1:0]    tx_sum_q, tx_sum_d;
   logic [SW-1:0]    rx_sum_q, rx_sum_d;
   logic [W-1:0]     prev_q, prev_d;
   logic [TW-1:0]    wait_q, wait_d;
   logic [3:0]       code_q, code_d;

   logic             cmd_rdy_q, cmd_rdy_d;
   logic             tx_vld_q, tx_vld_d;
   logic             tx_sop_q, tx_sop_d;
   logic             tx_eop_q, tx_eop_d;
   logic [W-1:0]     tx_dat_q, tx_dat_d;
   logic             stat_vld_q, stat_vld_d;
   logic             stat_pass_q, stat_pass_d;
   logic [3:0]       stat_code_q, stat_code_d;

   logic [31:0]      seed_eff;
   logic [31:0]      lfsr_nxt;
   logic [SW-1:0]    rx_sum_nxt;
   logic             rx_at_last;
   logic             rx_final;

   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return (s >> 1) ^ (s[0] ? POLY : 32'h0);
   endfunction

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      tx_cnt_d    = tx_cnt_q;
      rx_cnt_d    = rx_cnt_q;
      lfsr_d      = lfsr_q;
      tx_sum_d    = tx_sum_q;
      rx_sum_d    = rx_sum_q;
      prev_d      = prev_q;
      wait_d      = wait_q;
      code_d      = code_q;
      tx_vld_d    = tx_vld_q;
      tx_sop_d    = tx_sop_q;
      tx_eop_d    = tx_eop_q;
      tx_dat_d    = tx_dat_q;
      stat_vld_d  = 1'b0;
      stat_pass_d = 1'b0;
      stat_code_d = stat_code_q;

      seed_eff   = (cmd_seed == 32'h0) ? 32'h1 : cmd_seed;
      lfsr_nxt   = lfsr_step(lfsr_q);
      rx_sum_nxt = rx_sum_q + SW'(rx_dat);
      rx_at_last = (rx_cnt_q == len_q - LEN_W'(1));
      rx_final   = rx_at_last || rx_eop;

      unique case (state_q)
         StIdle: begin
            if (cmd_vld && cmd_rdy_q) begin
               len_d    = cmd_len;
               lfsr_d   = seed_eff;
               tx_cnt_d = '0;
               rx_cnt_d = '0;
               tx_sum_d = '0;
               rx_sum_d = '0;
               prev_d   = '0;
               wait_d   = '0;
               code_d   = '0;
               if (cmd_len == '0) begin
                  code_d[CFrm] = 1'b1;
                  state_d      = StDone;
               end else begin
                  tx_vld_d = 1'b1;
                  tx_sop_d = 1'b1;
                  tx_eop_d = (cmd_len == LEN_W'(1));
                  tx_dat_d = seed_eff[W-1:0];
                  state_d  = StTx;
               end
            end
         end

         StTx: begin
            if (tx_vld_q && tx_rdy) begin
               tx_sum_d = tx_sum_q + SW'(tx_dat_q);
               lfsr_d   = lfsr_nxt;
               if (tx_eop_q) begin
                  tx_vld_d = 1'b0;
                  tx_sop_d = 1'b0;
                  tx_eop_d = 1'b0;
                  wait_d   = '0;
                  state_d  = StWaitRx;
               end else begin
                  tx_cnt_d = tx_cnt_q + LEN_W'(1);
                  tx_sop_d = 1'b0;
                  tx_eop_d = (tx_cnt_q + LEN_W'(1) == len_q - LEN_W'(1));
                  tx_dat_d = lfsr_nxt[W-1:0];
               end
            end
         end

         StWaitRx: begin
            if (rx_vld) begin
               rx_cnt_d = rx_cnt_q + LEN_W'(1);
               rx_sum_d = rx_sum_nxt;
               prev_d   = rx_dat;
               wait_d   = '0;
               // sop must mark beat 0 only, eop must mark beat len-1 only
               if (((rx_cnt_q == '0) != rx_sop) || (rx_eop != rx_at_last) || rx_err) begin
                  code_d[CFrm] = 1'b1;
               end
               if ((rx_cnt_q != '0) && (rx_dat < prev_q)) begin
                  code_d[COrd] = 1'b1;
               end
               if (rx_final) begin
                  if (rx_sum_nxt != tx_sum_q) begin
                     code_d[CSum] = 1'b1;
                  end
                  state_d = StDone;
               end
            end else if (wait_q == TW'(TMO - 1)) begin
               code_d[CTmo] = 1'b1;
               state_d      = StDone;
            end else begin
               wait_d = wait_q + TW'(1);
            end
         end

         StDone: begin
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase

      if (state_d == StDone) begin
         stat_vld_d  = 1'b1;
         stat_pass_d = (code_d == 4'h0);
         stat_code_d = code_d;
      end
      cmd_rdy_d = (state_d == StIdle);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= StIdle;
         len_q       <= '0;
         tx_cnt_q    <= '0;
         rx_cnt_q    <= '0;
         lfsr_q      <= '0;
         tx_sum_q    <= '0;
         rx_sum_q    <= '0;
         prev_q      <= '0;
         wait_q      <= '0;
         code_q      <= '0;
         cmd_rdy_q   <= 1'b0;
         tx_vld_q    <= 1'b0;
         tx_sop_q    <= 1'b0;
         tx_eop_q    <= 1'b0;
         tx_dat_q    <= '0;
         stat_vld_q  <= 1'b0;
         stat_pass_q <= 1'b0;
         stat_code_q <= '0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         tx_cnt_q    <= tx_cnt_d;
         rx_cnt_q    <= rx_cnt_d;
         lfsr_q      <= lfsr_d;
         tx_sum_q    <= tx_sum_d;
         rx_sum_q    <= rx_sum_d;
         prev_q      <= prev_d;
         wait_q      <= wait_d;
         code_q      <= code_d;
         cmd_rdy_q   <= cmd_rdy_d;
         tx_vld_q    <= tx_vld_d;
         tx_sop_q    <= tx_sop_d;
         tx_eop_q    <= tx_eop_d;
         tx_dat_q    <= tx_dat_d;
         stat_vld_q  <= stat_vld_d;
         stat_pass_q <= stat_pass_d;
         stat_code_q <= stat_code_d;
      end
   end

   assign cmd_rdy_r   = cmd_rdy_q;
   assign tx_vld_r    = tx_vld_q;
   assign tx_sop_r    = tx_sop_q;
   assign tx_eop_r    = tx_eop_q;
   assign tx_dat_r    = tx_dat_q;
   assign stat_vld_r  = stat_vld_q;
   assign stat_pass_r = stat_pass_q;
   assign stat_code_r = stat_code_q;

endmodule

// File: tb/tb_qs_src.sv
// Bench for qs_src: table of directed packets plus random packets, each reply's expected status
// computed by a queue-based model of the reply-checking rules.
module tb_qs_src;

   localparam int unsigned W     = 32;
   localparam int unsigned LEN_W = 8;
   localparam int unsigned TMO   = 16;
   localparam logic [31:0] POLY  = 32'h8020_0003;

   logic             clk;
   logic             rst;
   logic             cmd_vld;
   logic [LEN_W-1:0] cmd_len;
   logic [31:0]      cmd_seed;
   logic             cmd_rdy_r;
   logic             tx_vld_r;
   logic             tx_sop_r;
   logic             tx_eop_r;
   logic [W-1:0]     tx_dat_r;
   logic             tx_rdy;
   logic             rx_vld;
   logic             rx_sop;
   logic             rx_eop;
   logic             rx_err;
   logic [W-1:0]     rx_dat;
   logic             stat_vld_r;
   logic             stat_pass_r;
   logic [3:0]       stat_code_r;

   qs_src #(.W(W), .LEN_W(LEN_W), .TMO(TMO)) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_vld    (cmd_vld),
      .cmd_len    (cmd_len),
      .cmd_seed   (cmd_seed),
      .cmd_rdy_r  (cmd_rdy_r),
      .tx_vld_r   (tx_vld_r),
      .tx_sop_r   (tx_sop_r),
      .tx_eop_r   (tx_eop_r),
      .tx_dat_r   (tx_dat_r),
      .tx_rdy     (tx_rdy),
      .rx_vld     (rx_vld),
      .rx_sop     (rx_sop),
      .rx_eop     (rx_eop),
      .rx_err     (rx_err),
      .rx_dat     (rx_dat),
      .stat_vld_r (stat_vld_r),
      .stat_pass_r(stat_pass_r),
      .stat_code_r(stat_code_r)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         n_chk;
   int         n_fail;
   int         cyc;
   int         stat_cnt;
   int         xfer_cnt;
   int         st_cyc;
   logic       st_pass;
   logic [3:0] st_code;

   // Reply beats and expected tx words
   logic [W-1:0] wexp[$];
   logic [W-1:0] rd[$];
   logic         rs[$];
   logic         re[$];
   logic         rr[$];

   typedef struct {
      int          len;
      logic [31:0] seed;
      int          rdy;   // 0 always ready, 1 pattern 1,0,0,1, 2 random
      int          rep;   // 0 good, 1 swap arg/arg+1, 2 +1 at arg, 3 err at arg,
                          // 4 truncate to arg beats, 5 eop at arg, 6 no reply
      int          arg;
      logic        pass;
      logic [3:0]  code;
   } vec_t;

   vec_t vt[12];

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      stat_cnt = 0;
      xfer_cnt = 0;
   end
   always @(negedge clk) begin
      if (stat_vld_r) begin
         stat_cnt <= stat_cnt + 1;
         st_pass  <= stat_pass_r;
         st_code  <= stat_code_r;
         st_cyc   <= cyc;
      end
      if (tx_vld_r && tx_rdy) xfer_cnt <= xfer_cnt + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] lfsr_nx(input logic [31:0] s);
      return (s >> 1) ^ (s[0] ? POLY : 32'h0);
   endfunction

   // Walk the reply as the checker sees it: stop at beat len-1 or the first eop.
   function automatic logic [3:0] model_code(input int len, input logic [39:0] txsum);
      logic [3:0]  c;
      logic [39:0] s;
      bit          done;
      bit          last;
      c    = 4'h0;
      s    = '0;
      done = 0;
      for (int i = 0; i < rd.size() && !done; i++) begin
         last = (i == len - 1);
         if ((rs[i] != (i == 0)) || rr[i] || (re[i] != last)) c[0] = 1'b1;
         if (i > 0 && rd[i] < rd[i-1]) c[1] = 1'b1;
         s = s + 40'(rd[i]);
         if (last || re[i]) begin
            done = 1;
            if (s != txsum) c[2] = 1'b1;
         end
      end
      if (!done) c[3] = 1'b1;
      return c;
   endfunction

   task automatic run_pkt(input int len, input logic [31:0] seed, input int rdy, input int rep,
                          input int arg, input bit use_model, input logic xp,
                          input logic [3:0] xc);
      logic [31:0]  s;
      logic [39:0]  txsum;
      logic [W-1:0] t;
      logic [3:0]   ec;
      logic         ep;
      logic         r;
      int           idx;
      int           k;
      int           base_x;
      int           base_s;
      int           wait_entry;

      s     = (seed == 32'h0) ? 32'h1 : seed;
      txsum = '0;
      wexp.delete();
      rd.delete();
      rs.delete();
      re.delete();
      rr.delete();
      for (int i = 0; i < len; i++) begin
         wexp.push_back(s[W-1:0]);
         rd.push_back(s[W-1:0]);
         txsum = txsum + 40'(s[W-1:0]);
         s = lfsr_nx(s);
      end
      for (int i = 0; i < len; i++) begin
         for (int j = 0; j < len - 1 - i; j++) begin
            if (rd[j] > rd[j+1]) begin
               t       = rd[j];
               rd[j]   = rd[j+1];
               rd[j+1] = t;
            end
         end
         rs.push_back(i == 0);
         re.push_back(i == len - 1);
         rr.push_back(1'b0);
      end
      case (rep)
         1: begin
            t         = rd[arg];
            rd[arg]   = rd[arg+1];
            rd[arg+1] = t;
         end
         2: rd[arg] = rd[arg] + W'(1);
         3: rr[arg] = 1'b1;
         4: while (rd.size() > arg) begin
            void'(rd.pop_back());
            void'(rs.pop_back());
            void'(re.pop_back());
            void'(rr.pop_back());
         end
         5: re[arg] = 1'b1;
         6: begin
            rd.delete();
            rs.delete();
            re.delete();
            rr.delete();
         end
         default: ;
      endcase
      if (use_model) begin
         ec = model_code(len, txsum);
         ep = (ec == 4'h0);
      end else begin
         ec = xc;
         ep = xp;
      end

      k = 0;
      while (!cmd_rdy_r && k < 20) begin
         tick();
         k++;
      end
      chk("cmd_rdy_idle", cmd_rdy_r, 1);
      cmd_vld  = 1'b1;
      cmd_len  = LEN_W'(len);
      cmd_seed = seed;
      tick();
      cmd_vld  = 1'b0;
      cmd_len  = LEN_W'($urandom);
      cmd_seed = $urandom;
      chk("cmd_rdy_busy", cmd_rdy_r, 0);
      base_x = xfer_cnt;
      base_s = stat_cnt;

      idx = 0;
      k   = 0;
      while (idx < len && k < 1000) begin
         chk("tx_vld", tx_vld_r, 1);
         chk("tx_dat", tx_dat_r, wexp[idx]);
         chk("tx_sop", tx_sop_r, idx == 0);
         chk("tx_eop", tx_eop_r, idx == len - 1);
         case (rdy)
            0:       r = 1'b1;
            1:       r = (k % 4 == 0) || (k % 4 == 3);
            default: r = ($urandom % 2) == 1;
         endcase
         tx_rdy = r;
         // rx noise outside WAIT_RX must be ignored
         rx_vld = ($urandom % 2) == 1;
         rx_sop = ($urandom % 2) == 1;
         rx_eop = ($urandom % 2) == 1;
         rx_err = ($urandom % 2) == 1;
         rx_dat = W'($urandom);
         if (r) idx++;
         tick();
         k++;
      end
      tx_rdy = 1'b0;
      rx_vld = 1'b0;
      rx_err = 1'b0;
      chk("tx_beats_done", idx, len);
      chk("tx_vld_after", tx_vld_r, 0);
      chk("tx_xfers", xfer_cnt - base_x, len);
      wait_entry = cyc;

      for (int i = 0; i < rd.size(); i++) begin
         rx_vld = 1'b1;
         rx_dat = rd[i];
         rx_sop = rs[i];
         rx_eop = re[i];
         rx_err = rr[i];
         tick();
         rx_vld = 1'b0;
         rx_err = 1'b0;
         rx_dat = W'($urandom);
         if (rdy == 2) repeat ($urandom_range(2, 0)) tick();
      end

      k = 0;
      while (stat_cnt == base_s && k < 100) begin
         tick();
         k++;
      end
      chk("stat_seen", stat_cnt - base_s, 1);
      chk("stat_pass", st_pass, ep);
      chk("stat_code", st_code, ec);
      if (rep == 6 && len > 0) chk("tmo_cycles", st_cyc - wait_entry, TMO);
      tick();
      chk("stat_once", stat_cnt - base_s, 1);
      chk("stat_vld_low", stat_vld_r, 0);
      chk("cmd_rdy_back", cmd_rdy_r, 1);
   endtask

   initial begin
      logic [31:0] s;
      int          len;
      int          m;
      int          arg;

      n_chk    = 0;
      n_fail   = 0;
      rst      = 1'b0;
      cmd_vld  = 1'b0;
      cmd_len  = '0;
      cmd_seed = '0;
      tx_rdy   = 1'b0;
      rx_vld   = 1'b0;
      rx_sop   = 1'b0;
      rx_eop   = 1'b0;
      rx_err   = 1'b0;
      rx_dat   = '0;

      vt[0]  = '{4,   32'd1,       0, 0, 0, 1'b1, 4'b0000};
      vt[1]  = '{1,   32'h1234,    0, 0, 0, 1'b1, 4'b0000};
      vt[2]  = '{3,   32'd5,       1, 0, 0, 1'b1, 4'b0000};
      vt[3]  = '{3,   32'd5,       0, 0, 0, 1'b1, 4'b0000};
      vt[4]  = '{4,   32'd1,       0, 1, 1, 1'b0, 4'b0010};
      vt[5]  = '{4,   32'd1,       0, 2, 3, 1'b0, 4'b0100};
      // early eop also stops the sum one word short
      vt[6]  = '{4,   32'd1,       0, 5, 2, 1'b0, 4'b0101};
      vt[7]  = '{0,   32'd9,       0, 6, 0, 1'b0, 4'b0001};
      vt[8]  = '{5,   32'hBEEF,    0, 6, 0, 1'b0, 4'b1000};
      vt[9]  = '{4,   32'd0,       2, 0, 0, 1'b1, 4'b0000};
      vt[10] = '{6,   32'h55AA,    2, 3, 4, 1'b0, 4'b0001};
      vt[11] = '{255, 32'hACE1,    2, 0, 0, 1'b1, 4'b0000};

      repeat (3) tick();
      chk("rst_cmd_rdy", cmd_rdy_r, 0);
      chk("rst_tx_vld", tx_vld_r, 0);
      chk("rst_tx_sop", tx_sop_r, 0);
      chk("rst_tx_eop", tx_eop_r, 0);
      chk("rst_tx_dat", tx_dat_r, 0);
      chk("rst_stat_vld", stat_vld_r, 0);
      chk("rst_stat_pass", stat_pass_r, 0);
      chk("rst_stat_code", stat_code_r, 0);
      rst = 1'b1;
      chk("rdy_before_edge", cmd_rdy_r, 0);
      tick();
      chk("rdy_after_release", cmd_rdy_r, 1);

      for (int i = 0; i < 12; i++) begin
         run_pkt(vt[i].len, vt[i].seed, vt[i].rdy, vt[i].rep, vt[i].arg, 0,
                 vt[i].pass, vt[i].code);
      end

      // Reset while the third beat is on the bus
      s        = 32'd1;
      s        = lfsr_nx(lfsr_nx(s));
      m        = stat_cnt;
      cmd_vld  = 1'b1;
      cmd_len  = LEN_W'(4);
      cmd_seed = 32'd1;
      tick();
      cmd_vld = 1'b0;
      tx_rdy  = 1'b1;
      tick();
      tick();
      chk("rst_mid_beat2", tx_dat_r, s[W-1:0]);
      chk("rst_mid_vld", tx_vld_r, 1);
      rst = 1'b0;
      tick();
      chk("rst_mid_drop", tx_vld_r, 0);
      chk("rst_mid_rdy", cmd_rdy_r, 0);
      chk("rst_mid_dat", tx_dat_r, 0);
      tx_rdy = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      chk("rst_mid_rdy_rise", cmd_rdy_r, 1);
      repeat (TMO + 4) tick();
      chk("rst_mid_no_stat", stat_cnt - m, 0);

      for (int n = 0; n < 25; n++) begin
         len = $urandom_range(16, 1);
         m   = $urandom_range(5, 0);
         arg = 0;
         if (m == 1 && len < 2) m = 0;
         case (m)
            1:       arg = $urandom_range(len - 2, 0);
            2, 3, 5: arg = $urandom_range(len - 1, 0);
            4:       arg = $urandom_range(len - 1, 0);
            default: arg = 0;
         endcase
         run_pkt(len, $urandom, 2, m, arg, 1, 1'b0, 4'h0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
